// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the master side issues
// operands with a start request, the slave side reports progress and the result.
//
// Handshake: start acts as valid. It is accepted only on a rising edge where
// busy=0 and done=0 (the adder is idle), and that edge also captures a, b
// and cin. A start seen while busy or done is high is dropped, not queued.
// done is a one-cycle pulse that marks s/cout as holding a new result. s and
// cout then stay stable until the next result is loaded.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop compute a + b + cin,
// LSB first, one bit per clock. The result is published on s/cout with a done pulse.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sb;
  logic             carry_next;

  // Full-adder cell on the current LSBs.
  assign sb         = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign carry_next = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    s_d     = s_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        c_d    = carry_next;
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d = {sb, s_sr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // The last bit is folded straight into the published result so that
        // s never exposes the partially shifted sum.
        if (cnt_q == LAST_BIT) begin
          s_d     = s_sr_d;
          cout_d  = carry_next;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy  = (state_q == ADD);
  assign bus.done  = (state_q == DONE);
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a directed vector table, hand-written multi-cycle
// sequences, an exhaustive sweep and random operations against a sum model.
module tb_serial_adder;

  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge while the adder is idle; returns on a falling edge
  // one cycle after done, with {cout,s} of the completed operation.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        output logic [W:0] got);
    logic [W:0] prev;
    logic [W:0] e;
    int         busy_cycles;
    int         k;
    bit         seen;
    prev      = {bus.cout, bus.s};
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tc;
    bus.start = 1'b1;
    exp_q.push_back(ref_sum(ta, tb_v, tc));
    @(negedge clk);
    bus.start   = 1'b0;
    busy_cycles = 0;
    seen        = 1'b0;
    k           = 0;
    while (!seen && k < W + 4) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cycles++;
        chk("hold_prev_result", {bus.cout, bus.s}, prev);
        @(negedge clk);
        k++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    e   = exp_q.pop_front();
    got = {bus.cout, bus.s};
    if (seen) begin
      chk("busy_cycles", busy_cycles, W);
      chk("sum", {bus.cout, bus.s}, e);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("result_held", {bus.cout, bus.s}, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W:0]   got;
    logic [W:0]   e;
    logic [W-1:0] ra, rb, negb;
    logic         rc;
    int           done_cnt;
    int           last_done;
    int           k;

    tbl[0] = '{a: 4'd5,  b: 4'd3,  cin: 1'b0, s: 4'd8,  cout: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, s: 4'd0,  cout: 1'b1};
    tbl[2] = '{a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, cout: 1'b1};
    tbl[3] = '{a: 4'd6,  b: 4'd9,  cin: 1'b0, s: 4'd15, cout: 1'b0};
    tbl[4] = '{a: 4'd7,  b: 4'd8,  cin: 1'b1, s: 4'd0,  cout: 1'b1};
    tbl[5] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, s: 4'd0,  cout: 1'b0};
    tbl[6] = '{a: 4'd0,  b: 4'd0,  cin: 1'b1, s: 4'd1,  cout: 1'b0};
    tbl[7] = '{a: 4'd10, b: 4'd5,  cin: 1'b1, s: 4'd0,  cout: 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",  32'(bus.busy), 32'd0);
    chk("reset_done",  32'(bus.done), 32'd0);
    chk("reset_s",     32'(bus.s),    32'd0);
    chk("reset_cout",  32'(bus.cout), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // The first edge after reset release accepts start.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, got);
      chk("tbl_s",    32'(got[W-1:0]), 32'(tbl[i].s));
      chk("tbl_cout", 32'(got[W]),     32'(tbl[i].cout));
    end

    // start and operand changes while busy are ignored.
    bus.a = 4'd2; bus.b = 4'd2; bus.cin = 1'b0; bus.start = 1'b1;
    exp_q.push_back(ref_sum(4'd2, 4'd2, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 4'd5; bus.b = 4'd11;
    k = 0;
    while (!bus.done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("busy_ign_done_seen", 32'(bus.done), 32'd1);
    e = exp_q.pop_front();
    chk("busy_ign_sum", {bus.cout, bus.s}, e);
    chk("busy_ign_sum_const", {bus.cout, bus.s}, 5'd4);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("busy_ign_no_second_done", done_cnt, 0);

    // Back-to-back with start held high: done every W+2 cycles.
    bus.a = 4'd7; bus.b = 4'd8; bus.cin = 1'b1; bus.start = 1'b1;
    e = ref_sum(4'd7, 4'd8, 1'b1);
    done_cnt  = 0;
    last_done = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last_done >= 0) chk("b2b_interval", i - last_done, W + 2);
        chk("b2b_sum", {bus.cout, bus.s}, e);
        last_done = i;
        done_cnt++;
      end else if (last_done >= 0) begin
        chk("b2b_stable", {bus.cout, bus.s}, e);
      end
    end
    chk("b2b_first_done", last_done - (done_cnt - 1) * (W + 2), W);
    chk("b2b_pulses", done_cnt, 3);
    bus.start = 1'b0;
    k = 0;
    while ((bus.busy || bus.done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_drained", 32'(bus.busy | bus.done), 32'd0);

    // Asynchronous reset on the second ADD cycle aborts the operation.
    bus.a = 4'd5; bus.b = 4'd3; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_s",    32'(bus.s),    32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op(4'd6, 4'd9, 1'b0, got);
    chk("after_abort_sum", got, 5'd15);

    // Exhaustive sweep, also cross-checked as a - (-b) + cin.
    for (int i = 0; i < 512; i++) begin
      ra   = 4'(i);
      rb   = 4'(i >> 4);
      rc   = 1'(i >> 8);
      negb = 4'(0) - rb;
      run_op(ra, rb, rc, got);
      chk("sub_identity", 32'(got[W-1:0]), 32'(4'(ra - negb + 4'(rc))));
    end

    // Random operations with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, got);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
